apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB completer: the slave end of the team's APB interface, so the counterpart to the master side.
- Implements a small byte-strobed register file with a configurable wait-state count and error signalling.
- Responds only when its select bit is set; register contents are exported as a flat bus to downstream logic.
- Sits behind the APB master and decoder in every test harness and SoC slice that needs control/status registers.

Parameters:
ADDR_WIDTH, 3, address bus is ADDR_WIDTH+1 bits wide (bits [ADDR_WIDTH:0]); word index, no byte offset
SEL_WIDTH, 2, width of the select bus
SEL_INDEX, 0, select bit that addresses this slave (0..SEL_WIDTH-1)
WRITE_WIDTH, 32, data width (READ_WIDTH equals WRITE_WIDTH)
STRB_WIDTH, ceil(WRITE_WIDTH/8), derived localparam
NUM_REGS, 8, implemented registers, 1..2^(ADDR_WIDTH+1); index NUM_REGS-1 is the read-only ID register
WAIT_STATES, 0, extra access cycles with ready low (0..15)
ID_VALUE, 32'hA9B0_0001, constant returned by the ID register
PRIV_WRITE, 1, when 1, writes with prot[0]=0 are rejected

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
addr  in  ADDR_WIDTH+1  register word index
prot  in  3  protection attributes; only prot[0] is used
sel  in  SEL_WIDTH  slave selects
enable  in  1  access phase
write  in  1  1 = write, 0 = read
wdata  in  WRITE_WIDTH  write data
strb  in  STRB_WIDTH  byte-lane write strobes
ready  out  1  transfer complete
rdata  out  WRITE_WIDTH  read data; valid only while ready=1 and the transfer is a read
slv_err  out  1  error response; valid only while ready=1
regs_o  out  NUM_REGS*WRITE_WIDTH  register contents; reg i occupies bits [i*WRITE_WIDTH +: WRITE_WIDTH]

Behaviour:
- Reset (asynchronous, takes effect any time, including mid-transfer):
  - ready=0, rdata=0, slv_err=0, all writable registers=0, FSM=IDLE, wait counter=0.
  - An in-flight transfer is discarded with no register update.
- FSM has two states: IDLE and ACCESS.
- IDLE:
  - Leaves on a sampled setup phase (sel[SEL_INDEX]=1, enable=0).
  - On that edge it latches addr/write/wdata/strb/prot, computes err, loads the counter with WAIT_STATES and goes to ACCESS.
  - If counter=0 it also registers ready=1 together with rdata/slv_err.
- Error computation, err=1 when any of:
  - addr >= NUM_REGS
  - write to the ID register
  - PRIV_WRITE=1 and write=1 and prot[0]=0
- ACCESS with ready=0: decrement the counter; when it reaches 0, register ready=1 with the response.
- ACCESS with ready=1 sampled at an edge with enable=1 (the completion edge):
  - A write with err=0 updates byte lane k of the register iff strb[k]=1.
  - A write with err=1 leaves all registers unchanged.
  - ready, rdata and slv_err drop to 0 on the same edge; FSM returns to IDLE.
- Setup back-to-back with completion:
  - The completion edge cannot also be a setup edge for this slave.
  - The next setup is accepted on the following edge; minimum transfer is 2 cycles, giving 2 cycles per transfer back-to-back.
- Read data:
  - Register contents as of the setup edge, including a write completed on that same edge.
  - rdata=0 when err=1.
- Protocol violations:
  - sel[SEL_INDEX] dropping in ACCESS aborts: no write, outputs cleared, back to IDLE.
  - enable=1 in IDLE is ignored.
  - addr/wdata changing mid-access has no effect, because values are latched at setup.
- Select scope: other sel bits are ignored entirely.
- Last-lane strobe: when WRITE_WIDTH is not a multiple of 8, the last strobe covers only the remaining bits.
- regs_o: driven from the registers, so it reflects a write one edge after completion. The ID slot always holds ID_VALUE.

Decomposition:
- apb_pkg holds the FSM state enum (IDLE, ACCESS), the strobe-width function, and the default ID_VALUE constant.
- One sub-module, apb_byte_strb_reg: a single WRITE_WIDTH register with per-lane write enable. The register file is NUM_REGS-1 instances plus the constant ID.

Test Plan:
- Reset defaults: reset with WAIT_STATES=0, then write reg2=32'hDEAD_BEEF (strb=4'hF, prot=3'b001) and read it back -> ready high in the second cycle of each transfer, slv_err=0, rdata=32'hDEAD_BEEF, regs_o slot 2 matches.
- Partial strobe: write reg1=32'h1122_3344 with strb=4'hF, then 32'hAABB_CCDD with strb=4'b0101 -> read returns 32'h11BB_33DD.
- Error responses:
  - Read addr 9 (NUM_REGS=8) -> slv_err=1, rdata=0.
  - Write reg7 (ID) -> slv_err=1, read returns 32'hA9B0_0001.
  - Write with prot[0]=0 -> slv_err=1, register unchanged.
- Wait states: WAIT_STATES=3 -> ready low for 3 access cycles, high on the 4th, i.e. 5 cycles total from setup; back-to-back reads sustain one transfer per 5 cycles.
- Abort: drop sel mid-wait with WAIT_STATES=2 on a write of 32'h5555_5555 -> no ready pulse, register keeps its old value, next transfer completes normally.
- Reset mid-transfer: assert reset_n=0 asynchronously between edges during a pending write -> ready, slv_err and rdata go to 0 immediately, all registers read back 0 after release.

Source files
------------

// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB completer register file:
//   - apb_state_t  : two-state transfer FSM encoding (IDLE, ACCESS)
//   - APB_ID_VALUE : default constant returned by the read-only ID register
//   - strb_width() : number of byte-lane strobes needed for a data width
// ----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    localparam logic [31:0] APB_ID_VALUE = 32'hA9B0_0001;

    // One strobe per byte lane; a partial last lane still gets its own strobe.
    function automatic int strb_width(input int width);
        return (width + 7) / 8;
    endfunction

endpackage : apb_pkg

// File: rtl/apb_byte_strb_reg.sv
// ----------------------------------------------------------------------------
// apb_byte_strb_reg
// One WRITE_WIDTH-bit register with per-byte-lane write enables.
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset, clears the register
//   we       in   write enable for this register
//   strb     in   byte-lane strobes; lane k covers bits [8k +: 8] (the last
//                 lane covers only the remaining bits)
//   wdata    in   write data
//   q        out  register contents
// ----------------------------------------------------------------------------
module apb_byte_strb_reg
    import apb_pkg::*;
#(
    parameter  int WRITE_WIDTH = 32,
    localparam int STRB_WIDTH  = strb_width(WRITE_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   we,
    input  logic [STRB_WIDTH-1:0]  strb,
    input  logic [WRITE_WIDTH-1:0] wdata,
    output logic [WRITE_WIDTH-1:0] q
);

    // Expand lane strobes to a per-bit mask; bit b belongs to lane b/8, so a
    // short last lane naturally masks only the bits that exist.
    logic [WRITE_WIDTH-1:0] lane_mask;

    for (genvar b = 0; b < WRITE_WIDTH; b++) begin : g_mask
        assign lane_mask[b] = strb[b / 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (we) begin
            q <= (q & ~lane_mask) | (wdata & lane_mask);
        end
    end

endmodule : apb_byte_strb_reg

// File: rtl/apb_slave_regfile.sv
// ----------------------------------------------------------------------------
// apb_slave_regfile
// APB completer exposing a byte-strobed register file with programmable wait
// states and error signalling. Register NUM_REGS-1 is a read-only ID word.
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   addr     in   register word index (ADDR_WIDTH+1 bits, no byte offset)
//   prot     in   protection attributes; prot[0]=1 marks a privileged access
//   sel      in   slave selects; only sel[SEL_INDEX] is honoured
//   enable   in   access phase indicator
//   write    in   1 = write, 0 = read
//   wdata    in   write data
//   strb     in   byte-lane write strobes
//   ready    out  transfer complete
//   rdata    out  read data (meaningful while ready=1 on a read)
//   slv_err  out  error response (meaningful while ready=1)
//   regs_o   out  flat register image, reg i at [i*WRITE_WIDTH +: WRITE_WIDTH]
// ----------------------------------------------------------------------------
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter  int                     ADDR_WIDTH  = 3,
    parameter  int                     SEL_WIDTH   = 2,
    parameter  int                     SEL_INDEX   = 0,
    parameter  int                     WRITE_WIDTH = 32,
    parameter  int                     NUM_REGS    = 8,
    parameter  int                     WAIT_STATES = 0,
    parameter  logic [WRITE_WIDTH-1:0] ID_VALUE    = WRITE_WIDTH'(APB_ID_VALUE),
    parameter  bit                     PRIV_WRITE  = 1'b1,
    localparam int                     STRB_WIDTH  = strb_width(WRITE_WIDTH)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [ADDR_WIDTH:0]             addr,
    input  logic [2:0]                      prot,
    input  logic [SEL_WIDTH-1:0]            sel,
    input  logic                            enable,
    input  logic                            write,
    input  logic [WRITE_WIDTH-1:0]          wdata,
    input  logic [STRB_WIDTH-1:0]           strb,
    output logic                            ready,
    output logic [WRITE_WIDTH-1:0]          rdata,
    output logic                            slv_err,
    output logic [NUM_REGS*WRITE_WIDTH-1:0] regs_o
);

    localparam int         ID_IDX    = NUM_REGS - 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    apb_state_t             state;
    logic [3:0]             cnt;
    logic                   write_q;
    logic                   err_q;
    logic [ADDR_WIDTH:0]    addr_q;
    logic [WRITE_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]  strb_q;

    logic                   sel_me;
    logic                   setup_hit;
    logic                   err_in;
    logic                   wr_fire;
    logic [WRITE_WIDTH-1:0] setup_rdata;
    logic [WRITE_WIDTH-1:0] access_rdata;
    logic [WRITE_WIDTH-1:0] reg_file [NUM_REGS];

    // prot[2:1] and the other select bits carry no meaning for this slave.
    logic unused_bits;
    assign unused_bits = ^{prot[2:1], sel};

    assign sel_me    = sel[SEL_INDEX];
    assign setup_hit = (state == IDLE) && sel_me && !enable;

    // Error classification is done once, on the setup edge, from live inputs.
    always_comb begin
        err_in = 1'b0;
        if (int'(addr) >= NUM_REGS) begin
            err_in = 1'b1;
        end
        if (write && (int'(addr) == ID_IDX)) begin
            err_in = 1'b1;
        end
        if (PRIV_WRITE && write && !prot[0]) begin
            err_in = 1'b1;
        end
    end

    // Registers only change on a completion edge, so reading them later in
    // the wait phase still yields the contents as of the setup edge.
    function automatic logic [WRITE_WIDTH-1:0] read_word(
        input logic [ADDR_WIDTH:0] a,
        input logic                is_write,
        input logic                is_err
    );
        logic [WRITE_WIDTH-1:0] v;
        v = '0;
        if (!is_write && !is_err) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(a) == i) begin
                    v = reg_file[i];
                end
            end
        end
        return v;
    endfunction

    assign setup_rdata  = read_word(addr, write, err_in);
    assign access_rdata = read_word(addr_q, write_q, err_q);

    // Completion edge of an error-free write.
    assign wr_fire = (state == ACCESS) && sel_me && ready && enable
                     && write_q && !err_q;

    // Transfer FSM with registered response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ready   <= 1'b0;
            rdata   <= '0;
            slv_err <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup_hit) begin
                        state   <= ACCESS;
                        write_q <= write;
                        err_q   <= err_in;
                        cnt     <= WAIT_LOAD;
                        if (WAIT_LOAD == 4'd0) begin
                            ready   <= 1'b1;
                            slv_err <= err_in;
                            rdata   <= setup_rdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!sel_me) begin
                        // Select withdrawn mid-transfer: abandon it silently.
                        state   <= IDLE;
                        cnt     <= '0;
                        ready   <= 1'b0;
                        rdata   <= '0;
                        slv_err <= 1'b0;
                    end else if (!ready) begin
                        if (cnt <= 4'd1) begin
                            cnt     <= '0;
                            ready   <= 1'b1;
                            slv_err <= err_q;
                            rdata   <= access_rdata;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end else if (enable) begin
                        state   <= IDLE;
                        ready   <= 1'b0;
                        rdata   <= '0;
                        slv_err <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Address/data capture for the write; only meaningful while in ACCESS.
    always_ff @(posedge clk) begin
        if (setup_hit) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            strb_q  <= strb;
        end
    end

    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_reg
        localparam logic [ADDR_WIDTH:0] IDX = (ADDR_WIDTH + 1)'(i);

        apb_byte_strb_reg #(
            .WRITE_WIDTH (WRITE_WIDTH)
        ) u_reg (
            .clk     (clk),
            .reset_n (reset_n),
            .we      (wr_fire && (addr_q == IDX)),
            .strb    (strb_q),
            .wdata   (wdata_q),
            .q       (reg_file[i])
        );

        assign regs_o[i*WRITE_WIDTH +: WRITE_WIDTH] = reg_file[i];
    end

    assign reg_file[ID_IDX]                          = ID_VALUE;
    assign regs_o[ID_IDX*WRITE_WIDTH +: WRITE_WIDTH] = ID_VALUE;

endmodule : apb_slave_regfile

// File: tb/tb_apb_slave_regfile.sv
// ----------------------------------------------------------------------------
// tb_apb_slave_regfile
// Three completers share one APB bus, each on its own select bit and with a
// different wait-state count (0, 3, 2). Directed transfers with hand-computed
// expectations exercise each feature in its own task.
// ----------------------------------------------------------------------------
module tb_apb_slave_regfile;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  addr;
    logic [2:0]  prot;
    logic [2:0]  sel;
    logic        enable;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;

    logic [2:0]        ready;
    logic [2:0]        slv_err;
    logic [2:0][31:0]  rdata_a;
    logic [2:0][255:0] regs_a;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    apb_slave_regfile #(.SEL_WIDTH(3), .SEL_INDEX(0), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .prot(prot), .sel(sel),
        .enable(enable), .write(write), .wdata(wdata), .strb(strb),
        .ready(ready[0]), .rdata(rdata_a[0]), .slv_err(slv_err[0]), .regs_o(regs_a[0])
    );

    apb_slave_regfile #(.SEL_WIDTH(3), .SEL_INDEX(1), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .prot(prot), .sel(sel),
        .enable(enable), .write(write), .wdata(wdata), .strb(strb),
        .ready(ready[1]), .rdata(rdata_a[1]), .slv_err(slv_err[1]), .regs_o(regs_a[1])
    );

    apb_slave_regfile #(.SEL_WIDTH(3), .SEL_INDEX(2), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .prot(prot), .sel(sel),
        .enable(enable), .write(write), .wdata(wdata), .strb(strb),
        .ready(ready[2]), .rdata(rdata_a[2]), .slv_err(slv_err[2]), .regs_o(regs_a[2])
    );

    // One full APB transfer to slave s. cyc counts clock cycles from the setup
    // edge to the completion edge inclusive; t is when ready was first seen.
    task automatic xfer(input int s, input logic [3:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] st, input logic [2:0] p,
                        output logic [31:0] rd, output logic e, output int cyc,
                        output time t);
        int n;
        bit got;
        @(negedge clk);
        sel    = '0;
        sel[s] = 1'b1;
        addr   = a;
        write  = w;
        wdata  = d;
        strb   = st;
        prot   = p;
        enable = 1'b0;
        @(posedge clk);
        #1 enable = 1'b1;
        got = 0;
        n   = 0;
        rd  = '0;
        e   = 1'b0;
        t   = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ready[s]) begin
                got = 1;
                rd  = rdata_a[s];
                e   = slv_err[s];
                t   = $time;
            end
        end
        cyc = n + 1;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout slave %0d: ready=0 after %0d cycles, required ready=1", s, n);
        end
        @(posedge clk);
        #1;
        enable = 1'b0;
        sel    = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sel = '0; enable = 1'b0; write = 1'b0; addr = '0;
        wdata = '0; strb = '0; prot = '0;
        #12;
        vectors++;
        if (ready !== 3'b000) begin
            miscompares++; $display("FAIL reset_ready: got %b, expected 000", ready);
        end
        vectors++;
        if (slv_err !== 3'b000) begin
            miscompares++; $display("FAIL reset_slv_err: got %b, expected 000", slv_err);
        end
        vectors++;
        if (rdata_a[0] !== 32'h0) begin
            miscompares++; $display("FAIL reset_rdata: got %h, expected 0", rdata_a[0]);
        end
        vectors++;
        if (regs_a[0][223:0] !== 224'h0) begin
            miscompares++; $display("FAIL reset_regs: got %h, expected 0", regs_a[0][223:0]);
        end
        vectors++;
        if (regs_a[0][255:224] !== 32'hA9B0_0001) begin
            miscompares++; $display("FAIL reset_id_slot: got %h, expected a9b00001", regs_a[0][255:224]);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic e;
        int cyc;
        time t0, t1;
        xfer(0, 4'd2, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001, rd, e, cyc, t0);
        vectors++;
        if (cyc !== 2 || e !== 1'b0) begin
            miscompares++; $display("FAIL basic_write: got cyc=%0d err=%b, expected cyc=2 err=0", cyc, e);
        end
        xfer(0, 4'd2, 1'b0, 32'h0, 4'h0, 3'b001, rd, e, cyc, t1);
        vectors++;
        if (rd !== 32'hDEAD_BEEF || e !== 1'b0 || cyc !== 2) begin
            miscompares++;
            $display("FAIL basic_read: got %h err=%b cyc=%0d, expected deadbeef err=0 cyc=2", rd, e, cyc);
        end
        vectors++;
        if (t1 - t0 !== 20) begin
            miscompares++; $display("FAIL basic_b2b_period: got %0t, expected 20", t1 - t0);
        end
        vectors++;
        if (regs_a[0][95:64] !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL basic_regs_o: got %h, expected deadbeef", regs_a[0][95:64]);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd;
        logic e;
        int cyc;
        time t;
        xfer(0, 4'd1, 1'b1, 32'h1122_3344, 4'hF, 3'b001, rd, e, cyc, t);
        xfer(0, 4'd1, 1'b1, 32'hAABB_CCDD, 4'b0101, 3'b001, rd, e, cyc, t);
        xfer(0, 4'd1, 1'b0, 32'h0, 4'h0, 3'b001, rd, e, cyc, t);
        vectors++;
        if (rd !== 32'h11BB_33DD || e !== 1'b0) begin
            miscompares++; $display("FAIL strobe_read: got %h err=%b, expected 11bb33dd err=0", rd, e);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic e;
        int cyc;
        time t;
        xfer(0, 4'd9, 1'b0, 32'h0, 4'h0, 3'b001, rd, e, cyc, t);
        vectors++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            miscompares++; $display("FAIL err_oob_read: got %h err=%b, expected 0 err=1", rd, e);
        end
        xfer(0, 4'd7, 1'b1, 32'h1234_5678, 4'hF, 3'b001, rd, e, cyc, t);
        vectors++;
        if (e !== 1'b1) begin
            miscompares++; $display("FAIL err_id_write: got err=%b, expected 1", e);
        end
        xfer(0, 4'd7, 1'b0, 32'h0, 4'h0, 3'b001, rd, e, cyc, t);
        vectors++;
        if (rd !== 32'hA9B0_0001 || e !== 1'b0) begin
            miscompares++; $display("FAIL err_id_read: got %h err=%b, expected a9b00001 err=0", rd, e);
        end
        xfer(0, 4'd2, 1'b1, 32'h0000_0000, 4'hF, 3'b000, rd, e, cyc, t);
        vectors++;
        if (e !== 1'b1) begin
            miscompares++; $display("FAIL err_priv_write: got err=%b, expected 1", e);
        end
        xfer(0, 4'd2, 1'b0, 32'h0, 4'h0, 3'b000, rd, e, cyc, t);
        vectors++;
        if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
            miscompares++; $display("FAIL err_priv_unchanged: got %h err=%b, expected deadbeef err=0", rd, e);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic e;
        int cyc;
        time t0, t1;
        xfer(1, 4'd0, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b001, rd, e, cyc, t0);
        vectors++;
        if (cyc !== 5 || e !== 1'b0) begin
            miscompares++; $display("FAIL wait_write: got cyc=%0d err=%b, expected cyc=5 err=0", cyc, e);
        end
        xfer(1, 4'd0, 1'b0, 32'h0, 4'h0, 3'b001, rd, e, cyc, t0);
        vectors++;
        if (rd !== 32'hCAFE_F00D || cyc !== 5) begin
            miscompares++; $display("FAIL wait_read1: got %h cyc=%0d, expected cafef00d cyc=5", rd, cyc);
        end
        xfer(1, 4'd0, 1'b0, 32'h0, 4'h0, 3'b001, rd, e, cyc, t1);
        vectors++;
        if (rd !== 32'hCAFE_F00D || cyc !== 5) begin
            miscompares++; $display("FAIL wait_read2: got %h cyc=%0d, expected cafef00d cyc=5", rd, cyc);
        end
        vectors++;
        if (t1 - t0 !== 50) begin
            miscompares++; $display("FAIL wait_b2b_period: got %0t, expected 50", t1 - t0);
        end
        vectors++;
        if (regs_a[0][31:0] !== 32'h0) begin
            miscompares++; $display("FAIL wait_other_slave: got %h, expected 0", regs_a[0][31:0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic e;
        int cyc;
        time t;
        bit seen;
        xfer(2, 4'd3, 1'b1, 32'h1234_5678, 4'hF, 3'b001, rd, e, cyc, t);
        vectors++;
        if (cyc !== 4 || e !== 1'b0) begin
            miscompares++; $display("FAIL abort_setup_write: got cyc=%0d err=%b, expected cyc=4 err=0", cyc, e);
        end
        @(negedge clk);
        sel = 3'b100; addr = 4'd3; write = 1'b1; wdata = 32'h5555_5555;
        strb = 4'hF; prot = 3'b001; enable = 1'b0;
        @(posedge clk);
        #1 enable = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready[2] !== 1'b0) begin
            miscompares++; $display("FAIL abort_early_ready: got %b, expected 0", ready[2]);
        end
        sel = '0;
        enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready[2] === 1'b1) seen = 1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++; $display("FAIL abort_ready_pulse: got 1, expected 0");
        end
        vectors++;
        if (regs_a[2][127:96] !== 32'h1234_5678) begin
            miscompares++; $display("FAIL abort_reg_kept: got %h, expected 12345678", regs_a[2][127:96]);
        end
        xfer(2, 4'd3, 1'b0, 32'h0, 4'h0, 3'b001, rd, e, cyc, t);
        vectors++;
        if (rd !== 32'h1234_5678 || e !== 1'b0 || cyc !== 4) begin
            miscompares++;
            $display("FAIL abort_next_read: got %h err=%b cyc=%0d, expected 12345678 err=0 cyc=4", rd, e, cyc);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic e;
        int cyc;
        time t;
        @(negedge clk);
        sel = 3'b001; addr = 4'd5; write = 1'b1; wdata = 32'h0BAD_F00D;
        strb = 4'hF; prot = 3'b001; enable = 1'b0;
        @(posedge clk);
        #1 enable = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready[0] !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_pending: got ready=%b, expected 1", ready[0]);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (ready[0] !== 1'b0 || slv_err[0] !== 1'b0 || rdata_a[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got ready=%b err=%b rdata=%h, expected 0 0 0",
                     ready[0], slv_err[0], rdata_a[0]);
        end
        vectors++;
        if (regs_a[0][223:0] !== 224'h0 || regs_a[1][31:0] !== 32'h0) begin
            miscompares++; $display("FAIL rstmid_regs: got %h / %h, expected 0", regs_a[0][223:0], regs_a[1][31:0]);
        end
        sel = '0;
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        xfer(0, 4'd5, 1'b0, 32'h0, 4'h0, 3'b001, rd, e, cyc, t);
        vectors++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_read5: got %h err=%b, expected 0 err=0", rd, e);
        end
        xfer(0, 4'd2, 1'b0, 32'h0, 4'h0, 3'b001, rd, e, cyc, t);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++; $display("FAIL rstmid_read2: got %h, expected 0", rd);
        end
        xfer(1, 4'd0, 1'b0, 32'h0, 4'h0, 3'b001, rd, e, cyc, t);
        vectors++;
        if (rd !== 32'h0 || cyc !== 5) begin
            miscompares++; $display("FAIL rstmid_read_s1: got %h cyc=%0d, expected 0 cyc=5", rd, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_errors();
        test_wait_states();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_apb_slave_regfile
